led_matrix_ab: RTL and testbench
================================

Name: led_matrix_ab

Overview:
- Driver for an 8x8 LED matrix, controlled by two push switches, A and B.
- Each switch is synchronised and debounced. Each debounced press advances its own 0..8 counter.
- Rows 0-3 show counter A as a bar graph; rows 4-7 show counter B.
- Sits between the board switches/clock and the matrix row/column pins. Rows are scanned one at a time.

Parameters:
- SCAN_DIV, 1000: clk cycles each row stays selected (>=2).
- DEB_DIV, 100000: clk cycles between debounce samples (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- swA  input  1  switch A, active-high, asynchronous to clk.
- swB  input  1  switch B, active-high, asynchronous to clk.
- led_row  output  8  one-hot row select, active-high; bit i = row i.
- led_col  output  8  column data for the selected row, active-high (1 = LED on); bit j = column j.
- cnt_a  output  4  counter A value, 0..8.
- cnt_b  output  4  counter B value, 0..8.

Behaviour:
- Reset (async assert, deassert synchronous to clk): all registers clear.
  - led_row=8'h01, led_col=8'h00, cnt_a=cnt_b=0.
  - Row index=0, scan and debounce prescalers=0, synchronisers=0, debounced levels=0.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On the cycle it wraps, row index increments mod 8 (7 -> 0).
  - Each row is therefore held exactly SCAN_DIV cycles; a full frame is 8*SCAN_DIV cycles.
- Outputs are registered:
  - led_row = 1 << row index.
  - led_col = bar(count), recomputed every cycle from the current row index and counter.
  - Rows 0-3 use cnt_a; rows 4-7 use cnt_b.
  - bar(n) = (1<<n)-1, i.e. the n low columns lit: 0 -> 8'h00, 3 -> 8'h07, 8 -> 8'hFF.
  - Output latency is one clk after the row index or a counter changes.
  - led_row is never all-zero and never has more than one bit set.
- Synchroniser: each switch passes through 2 flip-flops before any use.
- Debounce:
  - Prescaler counts 0..DEB_DIV-1; its wrap generates a sample tick.
  - On each tick, the synchronised value is stored as the new sample and the previous sample is kept.
  - The debounced level updates to the sample only when the new and previous samples are equal.
  - Otherwise the debounced level holds.
- Press:
  - A 0->1 transition of the debounced level produces a single one-cycle press pulse.
  - Releasing the switch produces nothing.
- Counters:
  - A press pulse increments the counter by 1, and 8 wraps to 0.
  - A and B are independent; simultaneous presses increment both on the same cycle.
  - A switch held high gives exactly one increment.
- Glitch rejection: a pulse shorter than one sample interval that is captured by only one tick is rejected.
- Reset mid-operation immediately clears counters and scan state; display restarts at row 0.

Test Plan:
1. Reset: rst=1 for 10 cycles, then release.
   - During reset and at release: led_row=8'h01, led_col=8'h00, cnt_a=cnt_b=0.
2. Scan (SCAN_DIV=4):
   - led_row steps 01,02,04,...,80,01, each value held exactly 4 cycles.
   - led_col=0 throughout.
3. Press A (DEB_DIV=2): hold swA=1 for 20 cycles, then 0.
   - cnt_a becomes 1 exactly once.
   - On rows 0-3, led_col=8'h01; on rows 4-7, led_col=8'h00.
4. Wrap: 9 clean presses of B (each high 20 / low 20 cycles).
   - cnt_b sequence 1..8 then 0.
   - At cnt_b=8, rows 4-7 show 8'hFF; after the 9th press they show 8'h00.
5. Glitch and simultaneous (DEB_DIV=4):
   - swA high for 1 cycle -> cnt_a unchanged.
   - swA and swB asserted together for 40 cycles -> both counters +1 on the same cycle.
6. Reset mid-operation: with cnt_a=5 and row index=6, pulse rst asynchronously (not aligned to clk).
   - Counters go to 0 and led_row goes to 8'h01 before the next clk edge.

Source files
------------

// File: rtl/led_matrix_ab.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_ab
// Description : 8x8 LED matrix driver with two debounced push switches.
//               Each press of A or B advances a 0..8 counter; rows 0-3 show
//               counter A as a bar graph, rows 4-7 show counter B. Rows are
//               scanned one at a time with a registered one-hot row select.
// Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_ab #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_DIV  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swA,
  input  logic       swB,
  output logic [7:0] led_row,
  output logic [7:0] led_col,
  output logic [3:0] cnt_a,
  output logic [3:0] cnt_b
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEB_DIV  > 1) ? $clog2(DEB_DIV)  : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_DIV - 1);
  localparam logic [3:0]        CNT_MAX   = 4'd8;

  // Scan state
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [2:0]        row_q, row_d;
  logic              scan_wrap;

  // Debounce state; bit 1 of each synchroniser is the usable value
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              deb_tick;
  logic [1:0]        sa_q, sb_q;
  logic              samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic              deb_a_q, deb_a_d, deb_b_q, deb_b_d;
  logic              press_a, press_b;

  // Counters and registered outputs
  logic [3:0]        cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [7:0]        led_row_q, led_row_d, led_col_q, led_col_d;

  // n low columns lit; n never exceeds 8, so 1<<8 - 1 gives all ones
  function automatic logic [7:0] bar(input logic [3:0] n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  // Next-state logic for scan, debounce, counters and display
  always_comb begin
    scan_wrap = (scan_q == SCAN_LAST);
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    row_d     = scan_wrap ? row_q + 3'd1 : row_q;

    deb_tick  = (deb_cnt_q == DEB_LAST);
    deb_cnt_d = deb_tick ? '0 : deb_cnt_q + 1'b1;

    // The sample register holds the previous tick's value; the level only
    // follows when two consecutive samples agree, which rejects one-tick glitches.
    samp_a_d = deb_tick ? sa_q[1] : samp_a_q;
    samp_b_d = deb_tick ? sb_q[1] : samp_b_q;
    deb_a_d  = deb_a_q;
    deb_b_d  = deb_b_q;
    if (deb_tick && (sa_q[1] == samp_a_q)) deb_a_d = sa_q[1];
    if (deb_tick && (sb_q[1] == samp_b_q)) deb_b_d = sb_q[1];

    // Rising edge of the debounced level, seen on the cycle it is committed
    press_a = deb_a_d & ~deb_a_q;
    press_b = deb_b_d & ~deb_b_q;

    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (press_a) cnt_a_d = (cnt_a_q == CNT_MAX) ? 4'd0 : cnt_a_q + 4'd1;
    if (press_b) cnt_b_d = (cnt_b_q == CNT_MAX) ? 4'd0 : cnt_b_q + 4'd1;

    led_row_d = 8'd1 << row_q;
    led_col_d = bar(row_q[2] ? cnt_b_q : cnt_a_q);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q    <= '0;
      row_q     <= 3'd0;
      deb_cnt_q <= '0;
      sa_q      <= 2'b00;
      sb_q      <= 2'b00;
      samp_a_q  <= 1'b0;
      samp_b_q  <= 1'b0;
      deb_a_q   <= 1'b0;
      deb_b_q   <= 1'b0;
      cnt_a_q   <= 4'd0;
      cnt_b_q   <= 4'd0;
      led_row_q <= 8'h01;
      led_col_q <= 8'h00;
    end else begin
      scan_q    <= scan_d;
      row_q     <= row_d;
      deb_cnt_q <= deb_cnt_d;
      sa_q      <= {sa_q[0], swA};
      sb_q      <= {sb_q[0], swB};
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
      deb_a_q   <= deb_a_d;
      deb_b_q   <= deb_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      led_row_q <= led_row_d;
      led_col_q <= led_col_d;
    end
  end

  assign led_row = led_row_q;
  assign led_col = led_col_q;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_ab.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_matrix_ab
// Description : Self-checking bench for led_matrix_ab. Expected counter values
//               are queued when a press is driven and compared when the
//               counter output moves. A second instance with a slower
//               debounce tick covers glitch rejection and simultaneous presses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_matrix_ab;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swA = 1'b0;
  logic       swB = 1'b0;
  logic [7:0] led_row, led_col, led_row4, led_col4;
  logic [3:0] cnt_a, cnt_b, cnt_a4, cnt_b4;

  int n_checks = 0;
  int n_err    = 0;
  int ma = 0, mb = 0, m4a = 0, m4b = 0;
  int exp_a[$];
  int exp_b[$];
  bit mon_en = 1'b0;
  int pa = 0, pb = 0;

  always #5 clk = ~clk;

  led_matrix_ab #(.SCAN_DIV(4), .DEB_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .swA(swA), .swB(swB),
    .led_row(led_row), .led_col(led_col), .cnt_a(cnt_a), .cnt_b(cnt_b));

  led_matrix_ab #(.SCAN_DIV(4), .DEB_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .swA(swA), .swB(swB),
    .led_row(led_row4), .led_col(led_col4), .cnt_a(cnt_a4), .cnt_b(cnt_b4));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] bar_ref(input int n);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int inc9(input int v);
    return (v == 8) ? 0 : v + 1;
  endfunction

  // Drive one press; expected counter values go to the scoreboard now
  task automatic press(input bit a, input bit b, input int hi, input int lo);
    if (a) begin ma = inc9(ma); exp_a.push_back(ma); m4a = inc9(m4a); end
    if (b) begin mb = inc9(mb); exp_b.push_back(mb); m4b = inc9(m4b); end
    swA = a; swB = b;
    repeat (hi) @(negedge clk);
    swA = 1'b0; swB = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // One full frame: one-hot row select and bar graph of the matching counter
  task automatic check_frame();
    int idx;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idx = 0;
      for (int k = 0; k < 8; k++) if (led_row[k]) idx = k;
      check_eq("row_onehot", $countones(led_row), 1);
      check_eq((idx < 4) ? "col_a" : "col_b", led_col, bar_ref((idx < 4) ? ma : mb));
    end
  endtask

  // Scoreboard monitor: any counter movement must match the next queued value
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pa = cnt_a; pb = cnt_b;
      end else begin
        if (cnt_a != pa) begin
          if (exp_a.size() == 0) check_eq("cnt_a_spurious", cnt_a, pa);
          else check_eq("cnt_a", cnt_a, exp_a.pop_front());
          pa = cnt_a;
        end
        if (cnt_b != pb) begin
          if (exp_b.size() == 0) check_eq("cnt_b_spurious", cnt_b, pb);
          else check_eq("cnt_b", cnt_b, exp_b.pop_front());
          pb = cnt_b;
        end
      end
    end
  end

  initial begin
    int n, old_a4, old_b4;

    // Reset held for 10 cycles
    repeat (10) @(negedge clk);
    check_eq("rst_row", led_row, 8'h01);
    check_eq("rst_col", led_col, 8'h00);
    check_eq("rst_cnt_a", cnt_a, 0);
    check_eq("rst_cnt_b", cnt_b, 0);
    rst = 1'b0;
    #1;
    check_eq("rel_row", led_row, 8'h01);
    check_eq("rel_cnt_a", cnt_a, 0);

    // Scan: first step lands after SCAN_DIV cycles plus one output register
    n = 0;
    while (led_row != 8'h02 && n < 20) begin @(negedge clk); n++; end
    check_eq("first_row_step", n, 5);
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < 4; c++) begin
        check_eq("scan_row", led_row, 8'd1 << ((i + 1) % 8));
        check_eq("scan_col", led_col, 8'h00);
        @(negedge clk);
      end
    end
    mon_en = 1'b1;

    // Single held press of A
    press(1'b1, 1'b0, 20, 20);
    check_eq("drain_a", exp_a.size(), 0);
    check_frame();

    // Nine presses of B: 1..8 then wrap to 0
    for (int p = 0; p < 9; p++) begin
      press(1'b0, 1'b1, 20, 20);
      check_eq("drain_b", exp_b.size(), 0);
      if (p == 7) check_frame();
    end
    check_frame();

    // One-cycle glitch on A must be rejected by both instances
    swA = 1'b1;
    @(negedge clk);
    swA = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("glitch_a4", cnt_a4, m4a);
    check_eq("glitch_a", cnt_a, ma);

    // Simultaneous press: both counters of the slow instance move together
    old_a4 = m4a; old_b4 = m4b;
    ma = inc9(ma); exp_a.push_back(ma); m4a = inc9(m4a);
    mb = inc9(mb); exp_b.push_back(mb); m4b = inc9(m4b);
    swA = 1'b1; swB = 1'b1;
    n = 0;
    while (cnt_a4 == old_a4 && cnt_b4 == old_b4 && n < 40) begin @(negedge clk); n++; end
    check_eq("simul_a4", cnt_a4, m4a);
    check_eq("simul_b4", cnt_b4, m4b);
    repeat (40 - n) @(negedge clk);
    swA = 1'b0; swB = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("drain_a_sim", exp_a.size(), 0);
    check_eq("drain_b_sim", exp_b.size(), 0);

    // Bring A to 5, then reset asynchronously while row 6 is shown
    repeat (3) press(1'b1, 1'b0, 20, 20);
    check_eq("drain_a5", exp_a.size(), 0);
    check_eq("cnt_a_is5", cnt_a, 5);
    n = 0;
    while (led_row != 8'h40 && n < 40) begin @(negedge clk); n++; end
    check_eq("reach_row6", led_row, 8'h40);
    @(negedge clk);
    mon_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_eq("async_cnt_a", cnt_a, 0);
    check_eq("async_cnt_b", cnt_b, 0);
    check_eq("async_row", led_row, 8'h01);
    check_eq("async_col", led_col, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ma = 0; mb = 0; m4a = 0; m4b = 0;
    @(negedge clk);
    check_eq("post_rst_row", led_row, 8'h01);
    mon_en = 1'b1;
    press(1'b1, 1'b0, 20, 20);
    check_eq("drain_a_post", exp_a.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
